// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Result is computed at start, held in hi_tmp/lo_tmp, committed at the end.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data1_E,
   input  logic [31:0] data2_E,
   input  logic [2:0]  mdop,
   input  logic        start_E,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_tmp_q, hi_tmp_d;
   logic [31:0] lo_tmp_q, lo_tmp_d;

   logic        mul_sgn;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] prod;

   logic        div_sgn;
   logic        a_neg;
   logic        b_neg;
   logic        div_zero;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic [31:0] quot;
   logic [31:0] rem;

   // 64-bit product; sign-extending both operands makes the low 64 bits right
   always_comb begin
      mul_sgn = (mdop == OP_MULT);
      mul_a   = {{32{mul_sgn & data1_E[31]}}, data1_E};
      mul_b   = {{32{mul_sgn & data2_E[31]}}, data2_E};
      prod    = mul_a * mul_b;
   end

   // signed divide via magnitudes so 0x80000000 / -1 needs no special case
   always_comb begin
      div_sgn  = (mdop == OP_DIV);
      a_neg    = div_sgn & data1_E[31];
      b_neg    = div_sgn & data2_E[31];
      div_zero = (data2_E == 32'd0);
      div_a    = a_neg ? (32'd0 - data1_E) : data1_E;
      div_b    = b_neg ? (32'd0 - data2_E) : data2_E;
      q_u      = 32'd0;
      r_u      = 32'd0;
      if (!div_zero) begin
         q_u = div_a / div_b;
         r_u = div_a % div_b;
      end
      quot = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
      rem  = a_neg ? (32'd0 - r_u) : r_u;
   end

   // control: accept ops in IDLE, count down in RUN, commit on the last edge
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_E) begin
               case (mdop)
                  OP_MULT, OP_MULTU: begin
                     hi_tmp_d = prod[63:32];
                     lo_tmp_d = prod[31:0];
                     cnt_d    = MULT_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     // divide by zero re-commits the current HI/LO
                     hi_tmp_d = div_zero ? hi_q : rem;
                     lo_tmp_d = div_zero ? lo_q : quot;
                     cnt_d    = DIV_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = data1_E;
                  OP_MTLO: lo_d = data1_E;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               hi_d    = hi_tmp_q;
               lo_d    = lo_tmp_q;
               state_d = S_IDLE;
            end
         end
      endcase
      busy_d = (state_d == S_RUN);
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         busy_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         hi_tmp_q <= 32'd0;
         lo_tmp_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_tmp_q <= hi_tmp_d;
         lo_tmp_q <= lo_tmp_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table plus corner sequences for md_unit.
// Expected HI/LO/latency are queued at issue and checked at completion.
module tb_md_unit;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [31:0] data1_E;
   logic [31:0] data2_E;
   logic [2:0]  mdop;
   logic        start_E;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int total;
   int bad;
   exp_t sb[$];
   vec_t vecs[9];

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk),
      .reset(reset),
      .data1_E(data1_E),
      .data2_E(data2_E),
      .mdop(mdop),
      .start_E(start_E),
      .busy(busy),
      .hi(hi),
      .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // issue one op, push expectation, count busy cycles, pop and compare
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input int ec,
                         input bit inject);
      int cyc;
      int w;
      logic [31:0] h0;
      logic [31:0] l0;
      exp_t e;
      w = 0;
      while (busy && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      h0 = hi;
      l0 = lo;
      mdop = op;
      data1_E = a;
      data2_E = b;
      start_E = 1'b1;
      sb.push_back('{hi: eh, lo: el, cyc: ec});
      @(posedge clk); #1;
      start_E = 1'b0;
      mdop = OP_NONE;
      data1_E = $urandom;
      data2_E = $urandom;
      cyc = 0;
      while (busy && cyc < 40) begin
         chk("hold_hi", hi, h0);
         chk("hold_lo", lo, l0);
         cyc++;
         if (inject && cyc == 2) begin
            start_E = 1'b1;
            mdop = OP_MTLO;
            data1_E = 32'h0000DEAD;
         end else if (inject && cyc == 3) begin
            start_E = 1'b1;
            mdop = OP_DIV;
            data1_E = 32'd100;
            data2_E = 32'd7;
         end
         @(posedge clk); #1;
         start_E = 1'b0;
         mdop = OP_NONE;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("busy_cycles", 32'(cyc), 32'(e.cyc));
         chk("res_hi", hi, e.hi);
         chk("res_lo", lo, e.lo);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      start_E = 1'b0;
      mdop = OP_NONE;
      data1_E = 32'd0;
      data2_E = 32'd0;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002,
                  32'hFFFFFFFF, 32'hFFFFFFFE, 5};
      vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002,
                  32'h00000001, 32'hFFFFFFFE, 5};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002,
                  32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3] = '{OP_DIVU,  32'd7, 32'd2,
                  32'd1, 32'd3, 10};
      vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h80000000, 10};
      vecs[5] = '{OP_MULT,  32'h80000000, 32'h80000000,
                  32'h40000000, 32'h00000000, 5};
      vecs[6] = '{OP_DIV,   32'd7, 32'hFFFFFFFE,
                  32'd1, 32'hFFFFFFFD, 10};
      vecs[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,
                  32'd5, 32'h19999999, 10};
      vecs[8] = '{OP_MULT,  32'hFFFFFFFD, 32'd4,
                  32'hFFFFFFFF, 32'hFFFFFFF4, 5};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);

      // none-ops have no effect
      mdop = 3'b111;
      start_E = 1'b1;
      @(posedge clk); #1;
      start_E = 1'b0;
      mdop = OP_NONE;
      chk("nop_busy", {31'd0, busy}, 32'd0);
      chk("nop_hi", hi, 32'd0);

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].cyc, 1'b0);

      // mthi/mtlo: single cycle, no busy
      mdop = OP_MTHI;
      data1_E = 32'h12345678;
      start_E = 1'b1;
      @(posedge clk); #1;
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      mdop = OP_MTLO;
      data1_E = 32'h9ABCDEF0;
      @(posedge clk); #1;
      start_E = 1'b0;
      mdop = OP_NONE;
      chk("mtlo_lo", lo, 32'h9ABCDEF0);
      chk("mtlo_hi", hi, 32'h12345678);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      // divide by zero keeps HI/LO
      run_op(OP_DIVU, 32'd55, 32'd0,
             32'h12345678, 32'h9ABCDEF0, 10, 1'b0);
      run_op(OP_DIV, 32'hFFFFFF00, 32'd0,
             32'h12345678, 32'h9ABCDEF0, 10, 1'b0);

      // starts during busy are ignored
      run_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);
      // back-to-back in the first idle cycle
      run_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 5, 1'b0);

      // asynchronous reset mid-divide
      mdop = OP_DIV;
      data1_E = 32'd100;
      data2_E = 32'd7;
      start_E = 1'b1;
      @(posedge clk); #1;
      start_E = 1'b0;
      mdop = OP_NONE;
      @(posedge clk); #1;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_hi", hi, 32'd0);
      chk("post_rst_lo", lo, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      run_op(OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits in the E stage next to the combinational ALU, takes the same forwarded operands, and runs mult/multu/div/divu over several cycles. It reports `busy` so the hazard unit can stall later HI/LO instructions in D. mthi/mtlo writes complete in a single cycle.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- data1_E  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- data2_E  input  32  rt operand (divisor / multiplier)
- mdop  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- start_E  input  1  qualifies mdop for one cycle; only sampled when asserted
- busy  output  1  registered; high while an operation is in flight
- hi  output  32  HI register, direct register output
- lo  output  32  LO register, direct register output

## Operation
- States: IDLE, RUN. A 4-bit down-counter `cnt` runs only in RUN.
- IDLE, start_E=1, mdop in {mult, multu, div, divu}:
  - Compute the result from data1_E/data2_E in the same cycle and latch it into internal `hi_tmp`/`lo_tmp`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES and go to RUN.
- IDLE, start_E=1, mdop=mthi: hi <= data1_E on that edge. mtlo works the same way for lo. busy stays 0.
- IDLE, start_E=1, mdop in {000, 111}: no effect.
- RUN: decrement `cnt` every edge. On the edge where `cnt`==1, do all of the following together: hi <= hi_tmp, lo <= lo_tmp, go to IDLE.
- RUN, start_E=1 with any mdop: ignored completely, including mthi/mtlo. hi/lo do not change and the operation in flight is not disturbed. The pipeline prevents this case; the block must still tolerate it.
- Arithmetic:
  - mult: signed 32x32 to 64; hi = [63:32], lo = [31:0].
  - multu: the same, unsigned.
  - div: lo = quotient, truncated toward zero. hi = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Divide by zero (data2_E = 0, div or divu): still takes DIV_CYCLES. hi and lo keep their previous values at completion.
- hi/lo are not visible mid-operation. They hold their old values until the completion edge.

## Timing
- Reset (asynchronous, any time, including mid-RUN): state=IDLE, cnt=0, busy=0, hi=0, lo=0, hi_tmp=0, lo_tmp=0. Any operation in flight is discarded.
- With start sampled at edge T and an N-cycle operation:
  - busy=1 in the N cycles after edge T.
  - hi/lo hold new values, and busy=0, after edge T+N.
- A new start is accepted in the first cycle in which busy=0.
- mthi/mtlo: the new value is visible the cycle after the start edge.
- The hazard unit stalls a D-stage mult/div/mfhi/mflo/mthi/mtlo while (start_E | busy). This block does not generate the stall itself.
- Operands only need to be valid in the start cycle.

## Test plan
- Reset check: release reset → busy=0, hi=0, lo=0. Assert reset 2 cycles into a div → busy=0 and hi=lo=0 immediately, asynchronously.
- mult 0xFFFFFFFF × 0x00000002:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged during busy.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- Signed and unsigned divide:
  - div 0xFFFFFFF9 / 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles.
  - divu 7 / 2 → lo=3, hi=1.
- Divide by zero: mthi 0x12345678, then mtlo 0x9ABCDEF0 (each visible next cycle, busy stays 0), then divu x/0 → busy for 10 cycles, hi/lo unchanged.
- Start while busy:
  - Issue mult 3×4, then during busy pulse start_E with mtlo 0xDEAD and with div.
  - Required: both ignored; after 5 cycles hi=0, lo=12.
  - Back-to-back start in the first idle cycle is accepted.
